// File: rtl/ghash_pkg.sv
// rtl/ghash_pkg.sv - GHASH shared constants, FSM encoding and bit-order helper
package ghash_pkg;

  localparam int NB_BLOCK_DEF = 128;

  // Reduction constant in GCM reflected order: 0xE1 followed by 120 zeros
  localparam logic [NB_BLOCK_DEF-1:0] GHASH_R = {8'hE1, 120'h0};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } ghash_state_t;

  function automatic logic [NB_BLOCK_DEF-1:0] bit_reverse(input logic [NB_BLOCK_DEF-1:0] v);
    logic [NB_BLOCK_DEF-1:0] r;
    for (int i = 0; i < NB_BLOCK_DEF; i++) begin
      r[i] = v[NB_BLOCK_DEF-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf128_mul_unreduced.sv
// rtl/gf128_mul_unreduced.sv - carry-less GF(2^128) product without reduction
// Inputs are GCM reflected; o_prod is normal order (bit k = coefficient of x^k).
module gf128_mul_unreduced #(
  parameter int NB_BLOCK = 128
) (
  input  logic [NB_BLOCK-1:0]   i_a,
  input  logic [NB_BLOCK-1:0]   i_b,
  output logic [2*NB_BLOCK-2:0] o_prod
);

  logic [NB_BLOCK-1:0]   a_norm;
  logic [2*NB_BLOCK-2:0] prod;

  always_comb begin
    a_norm = '0;
    for (int i = 0; i < NB_BLOCK; i++) begin
      a_norm[i] = i_a[NB_BLOCK-1-i];
    end
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < NB_BLOCK; i++) begin
      if (i_b[NB_BLOCK-1-i]) begin
        prod = prod ^ ({{(NB_BLOCK-1){1'b0}}, a_norm} << i);
      end
    end
  end

  assign o_prod = prod;

endmodule

// File: rtl/ghash_nblock_accum.sv
// rtl/ghash_nblock_accum.sv - multi-block-per-beat GHASH accumulator
// Each beat folds up to N_BLOCKS blocks into Y in one cycle using H^m..H^1.
module ghash_nblock_accum
  import ghash_pkg::*;
#(
  parameter int NB_BLOCK = NB_BLOCK_DEF,
  parameter int N_BLOCKS = 4,
  parameter int NB_DATA  = N_BLOCKS * NB_BLOCK
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NB_DATA-1:0]           i_data_x,
  input  logic [N_BLOCKS*NB_BLOCK-1:0] i_h_key_powers,
  input  logic [N_BLOCKS-1:0]          i_skip_bus,
  input  logic                         i_valid,
  input  logic                         i_sop,
  input  logic                         i_eop,
  output logic [NB_BLOCK-1:0]          o_data_y,
  output logic                         o_valid,
  output logic                         o_error
);

  localparam int NB_PROD = 2 * NB_BLOCK - 1;
  localparam logic [NB_BLOCK-1:0] POLY_LOW = bit_reverse(GHASH_R);

  ghash_state_t        state_q, state_d;
  logic [NB_BLOCK-1:0] y_q, y_d;
  logic [NB_BLOCK-1:0] data_y_d;
  logic                valid_d, error_d;

  logic [NB_BLOCK-1:0] y_prior, y_red, y_new;
  logic [NB_BLOCK-1:0] op_a [N_BLOCKS];
  logic [NB_BLOCK-1:0] op_h [N_BLOCKS];
  logic [NB_PROD-1:0]  prod [N_BLOCKS];
  logic [NB_PROD-1:0]  acc, red;
  int                  m_cnt;
  logic                thermo_ok;

  always_comb begin
    m_cnt     = 0;
    thermo_ok = 1'b1;
    for (int k = 0; k < N_BLOCKS; k++) begin
      if (!i_skip_bus[k]) m_cnt = m_cnt + 1;
    end
    // A present block above a skipped one breaks the thermometer code
    for (int k = 1; k < N_BLOCKS; k++) begin
      if (i_skip_bus[k-1] && !i_skip_bus[k]) thermo_ok = 1'b0;
    end
  end

  assign y_prior = i_sop ? '0 : y_q;

  // Block j of m present blocks is weighted by H^(m-j), held in slot m-1-j
  always_comb begin
    for (int j = 0; j < N_BLOCKS; j++) begin
      op_a[j] = i_data_x[j*NB_BLOCK +: NB_BLOCK];
      op_h[j] = '0;
      if (j < m_cnt) begin
        op_h[j] = i_h_key_powers[(m_cnt-1-j)*NB_BLOCK +: NB_BLOCK];
      end
    end
    op_a[0] = op_a[0] ^ y_prior;
  end

  for (genvar j = 0; j < N_BLOCKS; j++) begin : g_mul
    gf128_mul_unreduced #(
      .NB_BLOCK(NB_BLOCK)
    ) u_mul (
      .i_a   (op_a[j]),
      .i_b   (op_h[j]),
      .o_prod(prod[j])
    );
  end

  // Shared reduction: fold x^k (k >= 128) down as x^(k-128)*(1+x+x^2+x^7)
  always_comb begin
    acc = '0;
    for (int j = 0; j < N_BLOCKS; j++) begin
      acc = acc ^ prod[j];
    end
    red = acc;
    for (int k = NB_PROD - 1; k >= NB_BLOCK; k--) begin
      if (red[k]) begin
        red[k-NB_BLOCK +: NB_BLOCK] = red[k-NB_BLOCK +: NB_BLOCK] ^ POLY_LOW;
      end
    end
    y_red = bit_reverse(red[NB_BLOCK-1:0]);
  end

  assign y_new = (m_cnt == 0) ? y_prior : y_red;

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    data_y_d = o_data_y;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (i_valid) begin
      if (!thermo_ok) begin
        error_d = 1'b1;
      end else if (i_sop || state_q == ST_ACCUM) begin
        y_d = y_new;
        if (i_eop) begin
          data_y_d = y_new;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_ACCUM;
        end
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      y_q      <= '0;
      o_data_y <= '0;
      o_valid  <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      o_data_y <= data_y_d;
      o_valid  <= valid_d;
      o_error  <= error_d;
    end
  end

endmodule

// File: tb/tb_ghash_nblock_accum.sv
// tb/tb_ghash_nblock_accum.sv - scoreboard bench for ghash_nblock_accum
module tb_ghash_nblock_accum;

  localparam int NB = 128;
  localparam int N  = 4;
  localparam int ND = N * NB;
  localparam logic [NB-1:0] R_CONST = {8'hE1, 120'h0};
  localparam logic [NB-1:0] ONE     = {1'b1, 127'h0};

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] data_x;
  logic [ND-1:0] powers;
  logic [N-1:0]  skip;
  logic          valid, sop, eop;
  logic [NB-1:0] data_y;
  logic          out_valid, out_error;

  ghash_nblock_accum #(
    .NB_BLOCK(NB),
    .N_BLOCKS(N),
    .NB_DATA (ND)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_data_x      (data_x),
    .i_h_key_powers(powers),
    .i_skip_bus    (skip),
    .i_valid       (valid),
    .i_sop         (sop),
    .i_eop         (eop),
    .o_data_y      (data_y),
    .o_valid       (out_valid),
    .o_error       (out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [NB-1:0] val;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  exp_t          exp_q[$];
  int            err_q[$];
  logic [NB-1:0] h_key;
  logic [NB-1:0] msg[$];
  bit            in_msg = 0;
  exp_t          e;

  always @(posedge clk) cyc <= cyc + 1;

  // NIST bit-serial GF(2^128) multiply
  function automatic logic [NB-1:0] gmul(input logic [NB-1:0] x, input logic [NB-1:0] y);
    logic [NB-1:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < NB; i++) begin
      if (x[NB-1-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ R_CONST) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [NB-1:0] ghash_msg();
    logic [NB-1:0] y;
    y = '0;
    foreach (msg[i]) y = gmul(y ^ msg[i], h_key);
    return y;
  endfunction

  function automatic logic [NB-1:0] rblk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_key(input logic [NB-1:0] h);
    logic [NB-1:0] pw;
    h_key = h;
    pw = h;
    for (int k = 0; k < N; k++) begin
      powers[k*NB +: NB] = pw;
      pw = gmul(pw, h);
    end
  endtask

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one beat for one cycle and updates the message model
  task automatic beat(input bit s, input bit en, input logic [N-1:0] sk,
                      input logic [ND-1:0] d, input bit rst_now);
    int m;
    logic [N-1:0] good;
    m = 0;
    for (int k = 0; k < N; k++) if (!sk[k]) m++;
    good = '1;
    good = good << m;
    valid = 1'b1; sop = s; eop = en; skip = sk; data_x = d; rst = rst_now;
    if (rst_now) begin
      in_msg = 0;
    end else if (sk != good) begin
      err_q.push_back(cyc + 1);
    end else if (s || in_msg) begin
      if (s) msg.delete();
      for (int k = 0; k < m; k++) msg.push_back(d[k*NB +: NB]);
      if (en) begin
        exp_q.push_back('{cyc + 1, ghash_msg()});
        in_msg = 0;
      end else begin
        in_msg = 1;
      end
    end else begin
      err_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0; rst = 1'b0;
    data_x = {rblk(), rblk(), rblk(), rblk()};
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid y=%h cycle=%0d", data_y, cyc);
      end else begin
        e = exp_q.pop_front();
        if (data_y !== e.val || e.due != cyc) begin
          errors++;
          $display("FAIL ghash_result got=%h at cycle %0d expected=%h at cycle %0d",
                   data_y, cyc, e.val, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_valid got=none expected=%h due cycle %0d", e.val, e.due);
    end
    if (out_error) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_error got=1 expected=0 cycle=%0d", cyc);
      end else if (err_q.pop_front() != cyc) begin
        errors++;
        $display("FAIL error_timing got=cycle %0d expected=other cycle", cyc);
      end
    end else if (err_q.size() > 0 && err_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_error got=0 expected=1 due cycle %0d", err_q.pop_front());
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [NB-1:0] a, b, c, d;
    logic [NB-1:0] blk[6];
    logic [N-1:0]  sk;
    int            nb;

    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0;
    skip = '0; data_x = '0; powers = '0;
    idle(3);
    rst = 1'b0;
    chk("reset_data_y", data_y, '0);
    chk("reset_valid", {127'h0, out_valid}, '0);
    chk("reset_error", {127'h0, out_error}, '0);

    // Identity key: result is the XOR of the present blocks
    set_key(ONE);
    a = rblk(); b = rblk(); c = rblk(); d = rblk();
    beat(1, 1, 4'b0000, {d, c, b, a}, 0);
    idle(2);
    chk("identity_model", exp_q.size() == 0 ? '0 : '1, '0);
    beat(1, 1, 4'b1100, {d, c, b, a}, 0);
    beat(1, 0, 4'b0000, {d, c, b, a}, 0);
    beat(0, 1, 4'b1111, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(1, 1, 4'b1111, {d, c, b, a}, 0);
    idle(2);

    // Same 6-block message in three beat shapes
    set_key(rblk());
    for (int i = 0; i < 6; i++) blk[i] = rblk();
    beat(1, 0, 4'b0000, {blk[3], blk[2], blk[1], blk[0]}, 0);
    beat(0, 1, 4'b1100, {rblk(), rblk(), blk[5], blk[4]}, 0);
    idle(2);
    beat(1, 0, 4'b1100, {rblk(), rblk(), blk[1], blk[0]}, 0);
    idle(2);
    beat(0, 0, 4'b1100, {rblk(), rblk(), blk[3], blk[2]}, 0);
    idle(1);
    beat(0, 1, 4'b1100, {rblk(), rblk(), blk[5], blk[4]}, 0);
    for (int i = 0; i < 6; i++) begin
      beat(i == 0, i == 5, 4'b1110, {rblk(), rblk(), rblk(), blk[i]}, 0);
      idle($urandom_range(0, 3));
    end
    idle(2);

    // Protocol violations and restart
    beat(0, 0, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(1, 0, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(0, 0, 4'b0101, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(0, 1, 4'b1100, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(1, 0, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(1, 0, 4'b1000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(0, 1, 4'b1110, {rblk(), rblk(), rblk(), rblk()}, 0);
    idle(2);

    // Reset during the second beat of three
    beat(1, 0, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(0, 0, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 1);
    chk("abort_data_y", data_y, '0);
    chk("abort_valid", {127'h0, out_valid}, '0);
    chk("abort_error", {127'h0, out_error}, '0);
    beat(0, 1, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(1, 0, 4'b0000, {rblk(), rblk(), rblk(), rblk()}, 0);
    beat(0, 1, 4'b1000, {rblk(), rblk(), rblk(), rblk()}, 0);
    idle(2);

    // Back-to-back random messages
    set_key(rblk());
    for (int msg_i = 0; msg_i < 100; msg_i++) begin
      nb = $urandom_range(1, 3);
      for (int bi = 0; bi < nb; bi++) begin
        sk = '1;
        sk = sk << $urandom_range(0, N);
        beat(bi == 0, bi == nb - 1, sk, {rblk(), rblk(), rblk(), rblk()}, 0);
      end
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d expected=0", exp_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL pending_errors got=%0d expected=0", err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghash_nblock_accum.md
GHASH_NBLOCK_ACCUM -- requirements
Module: ghash_nblock_accum

Interface
REQ-001 SHALL have parameter NB_BLOCK, default 128: GF(2^128) block width in bits.
REQ-002 SHALL have parameter N_BLOCKS, default 4: blocks per beat, range 1..8.
REQ-003 SHALL have parameter NB_DATA, default N_BLOCKS*NB_BLOCK: beat data width.
REQ-004 SHALL have port i_clock, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_data_x, input, NB_DATA: beat data; block k at bits [k*NB_BLOCK +: NB_BLOCK]; block 0 is earliest in the message.
REQ-007 SHALL have port i_h_key_powers, input, N_BLOCKS*NB_BLOCK: slot k holds H^(k+1); stable for the whole message.
REQ-008 SHALL have port i_skip_bus, input, N_BLOCKS: bit k=1 means block k is absent.
REQ-009 SHALL have port i_valid, input, 1: beat qualifier.
REQ-010 SHALL have port i_sop, input, 1: first beat of message; qualified by i_valid.
REQ-011 SHALL have port i_eop, input, 1: last beat of message; qualified by i_valid.
REQ-012 SHALL have port o_data_y, output, NB_BLOCK: registered GHASH result.
REQ-013 SHALL have port o_valid, output, 1: one-cycle pulse marking a new o_data_y.
REQ-014 SHALL have port o_error, output, 1: one-cycle pulse on a protocol violation.

Function
REQ-015 Multiplication SHALL be GCM GF(2^128): polynomial x^128+x^7+x^2+x+1, reflected bit order; 0x80..00 is the identity.
REQ-016 Let m = number of zero bits in i_skip_bus. An accepted beat SHALL update Y' = (Y^X0)·H^m ^ X1·H^(m-1) ^ ... ^ X_(m-1)·H^1, using blocks 0..m-1.
REQ-017 i_skip_bus SHALL be thermometer-coded: zeros in the low bits, ones in the high bits. A non-thermometer beat SHALL pulse o_error, be discarded, and leave the state unchanged.
REQ-018 m=0, all blocks skipped, SHALL leave Y unchanged; eop on such a beat SHALL still complete the message.
REQ-019 The FSM SHALL have two states, IDLE and ACCUM; reset enters IDLE.
REQ-020 In either state, i_valid&i_sop SHALL load Y from REQ-016 with prior Y=0.
REQ-021 i_valid&i_sop&!i_eop SHALL move the FSM to ACCUM.
REQ-022 i_sop in ACCUM SHALL discard the open message silently and restart it.
REQ-023 In ACCUM, i_valid&!i_sop SHALL accumulate; with i_eop it SHALL also complete and return to IDLE.
REQ-024 i_valid&i_sop&i_eop SHALL be a single-beat message: it completes and stays in or returns to IDLE.
REQ-025 In IDLE, i_valid&!i_sop SHALL pulse o_error and be ignored.
REQ-026 Completion SHALL register o_data_y = final Y and pulse o_valid exactly one cycle after the eop beat: latency 1.
REQ-027 o_data_y SHALL hold its value until the next completion.
REQ-028 i_valid=0 SHALL hold Y and the FSM state, so gaps are allowed between beats.
REQ-029 There SHALL be no backpressure: one beat is accepted per cycle at full rate, and back-to-back messages SHALL be supported with eop followed directly by sop.
REQ-030 The Y update SHALL be a single combinational cycle: N_BLOCKS multipliers, an XOR tree on the unreduced 255-bit products, then one shared reduction.

Reset
REQ-031 On reset: FSM=IDLE, Y=0, o_data_y=0, o_valid=0, o_error=0.
REQ-032 Reset mid-message SHALL abort the message with no o_valid.
REQ-033 Reset SHALL take priority over a coincident i_valid beat.

Structure
REQ-034 Package ghash_pkg SHALL hold NB_BLOCK_DEF=128, the reduction constant R=0xE1 followed by 120 zeros, and the FSM state encoding.
REQ-035 Sub-module gf128_mul_unreduced SHALL be instantiated N_BLOCKS times; it is combinational and outputs the 255-bit product.
REQ-036 Reduction and the per-beat power-selection mux from m SHALL live in the top level.

Verification
REQ-037 Identity: N_BLOCKS=4; all powers = 0x80..00; one beat, sop+eop, skip=0000, X0..X3 = A,B,C,D -> o_data_y = A^B^C^D, o_valid one cycle later.
REQ-038 Partial beat: same as REQ-037 with skip=1100 -> o_data_y = A^B; skip=1111 on the eop beat -> Y unchanged.
REQ-039 Equivalence: random H, a 6-block message sent as beats 4+2 vs 2+2+2 vs 1x6 with idle gaps -> identical o_data_y, matching a software GHASH model.
REQ-040 Protocol: beat without sop in IDLE -> o_error pulse; skip=0101 -> o_error pulse and Y unchanged; sop mid-message -> restart, single o_valid.
REQ-041 Reset at the second beat of 3 -> no o_valid; all outputs 0; a following message computes correctly.
REQ-042 Back-to-back: 100 random messages with eop->sop on adjacent cycles -> every o_valid matches the model.
